// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the Bram read-port arbiter.
// The optional burst mode is enabled by defining BRAM_ARB_BURST_EN.
package bram_arb_pkg;

    localparam int unsigned MAX_NREQ = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Ceiling log2, never below 1 so that single-entry ranges still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: finds the first set request after ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan ptr+1 .. ptr+NREQ; the first requester seen wins.
    always_comb begin
        int unsigned pos;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = (32'(ptr) + k) % NREQ;
            if (!any && req[IW'(pos)]) begin
                any    = 1'b1;
                idx    = IW'(pos);
                onehot = NREQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter for the single Bram read port. Accepts one read per
// cycle, remembers which requester issued it and routes the one-cycle-late
// Bram response back to that requester.
// Define BRAM_ARB_BURST_EN to let a winner keep the port for up to
// MAX_BURST consecutive grants.
module bram_rd_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int unsigned NREQ      = 4,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned DWIDTH    = 32,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned AWIDTH    = clog2_min1(DEPTH)
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]      rsp_data,
    output logic                   bram_ren,
    output logic [AWIDTH-1:0]      bram_raddr,
    input  logic                   bram_rdv,
    input  logic [DWIDTH-1:0]      bram_rdata
);

    localparam int unsigned IW = clog2_min1(NREQ);

    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   tag_q;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [IW-1:0]   win_idx;
    logic            win_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef BRAM_ARB_BURST_EN
    localparam int unsigned CW = clog2_min1(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Burst FSM registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner keeps the port while it still requests and has budget left;
    // otherwise fall back to round-robin from the owner (ptr_q == owner).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        win_idx = pick_idx;
        win_any = pick_any;
        if (state_q == BURST && req[owner_q] && (32'(cnt_q) < MAX_BURST)) begin
            win_idx = owner_q;
            win_any = 1'b1;
            cnt_d   = cnt_q + CW'(1);
        end else if (pick_any) begin
            state_d = BURST;
            owner_d = pick_idx;
            cnt_d   = CW'(1);
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
`else
    // Pure per-cycle round-robin winner.
    always_comb begin
        win_idx = pick_idx;
        win_any = pick_any;
    end
`endif

    // Pointer and response tag follow every grant.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q <= IW'(NREQ - 1);
            tag_q <= '0;
        end else if (win_any) begin
            ptr_q <= win_idx;
            tag_q <= win_idx;
        end
    end

    // Grant, Bram read request and address mux; all held quiet during reset.
    always_comb begin
        gnt        = '0;
        bram_ren   = 1'b0;
        bram_raddr = '0;
        if (arst_n && win_any) begin
            gnt        = NREQ'(1) << win_idx;
            bram_ren   = 1'b1;
            bram_raddr = req_addr[win_idx*AWIDTH +: AWIDTH];
        end
    end

    // Response demux: Bram data is broadcast, valid steered by the tag.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = bram_rdata;
        if (arst_n && bram_rdv) begin
            rsp_valid = NREQ'(1) << tag_q;
        end
    end

endmodule
